div_restoring_dkg: RTL and testbench

Iterative unsigned restoring divider. It is the inverse companion to the Vedic MAC datapath: it takes a dividend and divisor of the MAC operand width and returns quotient and remainder. It resolves one quotient bit per clock, with a start/done handshake. Each trial subtraction is done by a ripple subtractor built from DKG reversible cells (B inverted, carry-in 1), so the block stays within the team's reversible-gate datapath style.

---
 rtl/div_restoring_dkg_pkg.sv | 22 ++
 rtl/div_restoring_dkg_sub_dkg_nbit.sv | 43 ++++
 rtl/div_restoring_dkg.sv | 154 +++++++++++++++
 tb/tb_div_restoring_dkg.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_restoring_dkg_pkg.sv
// Shared definitions for the restoring divider.
//   state_t      : controller state encoding (IDLE, RUN, FIN)
//   DEF_WIDTH    : default operand width (matches the Vedic MAC operand width)
//   DEF_CNT_W    : step-counter width for the default operand width
//   cnt_width()  : step-counter width for an arbitrary operand width
package div_restoring_dkg_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Counter holds WIDTH-1 down to 0; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_restoring_dkg_sub_dkg_nbit.sv
// N-bit ripple subtractor built from DKG reversible cells.
// DIFF = A - B, BORROW = 1 when B > A.
// Each cell is a DKG gate with A=0, B=A[i], C=~B[i], D=carry-in; with the
// control input tied low the R output is the full-adder carry and S is the sum.
// The P/Q garbage outputs are pass-throughs and are not materialised.
// Ports:
//   A      in  N  minuend
//   B      in  N  subtrahend
//   DIFF   out N  difference (mod 2^N)
//   BORROW out 1  inverse of the final carry
module sub_dkg_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] DIFF,
   output logic         BORROW
);

   logic [N:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_cell
      logic cell_a;
      logic cell_b;
      logic cell_c;
      logic cell_d;

      assign cell_a = 1'b0;
      assign cell_b = A[i];
      assign cell_c = ~B[i];
      assign cell_d = carry[i];

      // DKG R output: (A^B)(C^D) ^ CD
      assign carry[i+1] = ((cell_a ^ cell_b) & (cell_c ^ cell_d)) ^ (cell_c & cell_d);
      // DKG S output: B^C^D
      assign DIFF[i]    = cell_b ^ cell_c ^ cell_d;
   end

   assign BORROW = ~carry[N];

endmodule

// File: rtl/div_restoring_dkg.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_BYPASS_EN (divide-by-zero short cut + flag).
// Ports:
//   clk          in  1      clock, rising edge
//   reset        in  1      asynchronous active-low reset
//   start        in  1      request, taken in IDLE or FIN
//   dividend     in  WIDTH  sampled on the accepting edge
//   divisor      in  WIDTH  sampled on the accepting edge
//   busy         out 1      high in RUN
//   done         out 1      high for the FIN cycle
//   quotient     out WIDTH  result, held until the next done
//   remainder    out WIDTH  result, held until the next done
//   div_by_zero  out 1      divisor was zero (bypass build only, else 0)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one trial subtraction per cycle, counter WIDTH-1 down to 0
// FIN   | done pulse; results valid; start here restarts without a gap
module div_restoring_dkg
   import div_restoring_dkg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   q_work;
   logic [WIDTH:0]     r_work;
   logic [WIDTH-1:0]   dvsr;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     t_val;
   logic [WIDTH:0]     d_val;
   logic               borrow;
   logic [WIDTH:0]     r_step;
   logic [WIDTH-1:0]   q_step;
   logic               accept;
   logic               last_step;
   logic               zero_byp;
   logic               unused_r_msb;

   assign accept    = start && (state != RUN);
   assign last_step = (state == RUN) && (cnt == '0);

`ifdef DIV_ZERO_BYPASS_EN
   assign zero_byp = accept && (divisor == '0);
`else
   assign zero_byp = 1'b0;
`endif

   assign t_val  = {r_work[WIDTH-1:0], q_work[WIDTH-1]};

   sub_dkg_nbit #(
      .N (WIDTH + 1)
   ) u_sub (
      .A      (t_val),
      .B      ({1'b0, dvsr}),
      .DIFF   (d_val),
      .BORROW (borrow)
   );

   assign r_step = borrow ? t_val : d_val;
   assign q_step = {q_work[WIDTH-2:0], ~borrow};

   // The partial remainder never exceeds the divisor, so its top bit is
   // only kept for the full-width trial subtraction result.
   assign unused_r_msb = r_work[WIDTH];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = zero_byp ? FIN : RUN;
         end
         RUN: begin
            if (last_step) state_nxt = FIN;
         end
         FIN: begin
            if (start) state_nxt = zero_byp ? FIN : RUN;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == FIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         q_work    <= '0;
         r_work    <= '0;
         dvsr      <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            q_work <= dividend;
            r_work <= '0;
            dvsr   <= divisor;
            cnt    <= CNT_LOAD;
         end else if (state == RUN) begin
            q_work <= q_step;
            r_work <= r_step;
            cnt    <= cnt - 1'b1;
         end
         // Result registers are loaded on the edge entering FIN so they are
         // valid in the done cycle and untouched during RUN.
         if (last_step) begin
            quotient  <= q_step;
            remainder <= r_step[WIDTH-1:0];
         end else if (zero_byp) begin
            quotient  <= '1;
            remainder <= dividend;
         end
      end
   end

`ifdef DIV_ZERO_BYPASS_EN
   logic dbz_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dbz_q <= 1'b0;
      end else if (last_step) begin
         dbz_q <= 1'b0;
      end else if (zero_byp) begin
         dbz_q <= 1'b1;
      end
   end

   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_restoring_dkg.sv
module tb_div_restoring_dkg;

`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic       start8;
   logic [7:0] dvd8, dvs8, q8, r8;
   logic       busy8, done8, dz8;

   logic        start64;
   logic [63:0] dvd64, dvs64, q64, r64;
   logic        busy64, done64, dz64;

   div_restoring_dkg #(.WIDTH(8)) u_d8 (
      .clk(clk), .reset(reset), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
   );

   div_restoring_dkg #(.WIDTH(64)) u_d64 (
      .clk(clk), .reset(reset), .start(start64), .dividend(dvd64), .divisor(dvs64),
      .busy(busy64), .done(done64), .quotient(q64), .remainder(r64), .div_by_zero(dz64)
   );

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
   } exp_t;

   exp_t sb8[$];
   exp_t sb64[$];

   int errors = 0;
   int checks = 0;

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int w);
      exp_t        e;
      logic [63:0] m;
      m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      if (b == 64'd0) begin
         e.q  = m;
         e.r  = a;
         e.dz = BYP;
      end else begin
         e.q  = a / b;
         e.r  = a % b;
         e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic int exp_lat(input logic [63:0] b, input int w);
      return (BYP && b == 64'd0) ? 1 : w + 1;
   endfunction

   // Issue one operation and wait for done; lat = cycles from accepting edge
   // to the done cycle (-1 on timeout), bc = busy cycles seen before done.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output int bc, output logic [7:0] q, output logic [7:0] r,
                       output logic dz);
      @(negedge clk);
      start8 = 1'b1; dvd8 = a; dvs8 = b;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      lat = 1; bc = 0;
      while (!done8 && lat < 200) begin
         if (busy8) bc++;
         @(negedge clk);
         lat++;
      end
      if (!done8) lat = -1;
      q = q8; r = r8; dz = dz8;
      @(negedge clk);
   endtask

   task automatic run64(input logic [63:0] a, input logic [63:0] b, output int lat,
                        output int bc, output logic [63:0] q, output logic [63:0] r,
                        output logic dz);
      @(negedge clk);
      start64 = 1'b1; dvd64 = a; dvs64 = b;
      @(posedge clk);
      @(negedge clk);
      start64 = 1'b0; dvd64 = {$urandom, $urandom}; dvs64 = {$urandom, $urandom};
      lat = 1; bc = 0;
      while (!done64 && lat < 200) begin
         if (busy64) bc++;
         @(negedge clk);
         lat++;
      end
      if (!done64) lat = -1;
      q = q64; r = r64; dz = dz64;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start8 = 1'b0; dvd8 = '0; dvs8 = '0;
      start64 = 1'b0; dvd64 = '0; dvs64 = '0;
      #23;
      checks++;
      if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                  busy8, done8, q8, r8, dz8);
      end
      checks++;
      if ({busy64, done64, q64, r64, dz64} !== 131'd0) begin
         errors++;
         $display("FAIL reset64: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                  busy64, done64, q64, r64, dz64);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || busy64 !== 1'b0 || done64 !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy8=%b done8=%b busy64=%b done64=%b expected 0",
                  busy8, done8, busy64, done64);
      end
   endtask

   task automatic test_basic8();
      logic [7:0] a_tab [6] = '{8'h80, 8'h01, 8'hFF, 8'hFE, 8'h64, 8'h00};
      logic [7:0] b_tab [6] = '{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h0A, 8'h05};
      int lat, bc;
      logic [7:0] q, r;
      logic dz;
      exp_t e;

      sb8.push_back('{64'h24, 64'h03, 1'b0});
      run8(8'hFF, 8'h07, lat, bc, q, r, dz);
      e = sb8.pop_front();
      checks++;
      if (lat != 9 || bc != 8) begin
         errors++;
         $display("FAIL lat_ff_7: got lat=%0d busy=%0d expected lat=9 busy=8", lat, bc);
      end
      checks++;
      if (q !== e.q[7:0] || r !== e.r[7:0] || dz !== e.dz) begin
         errors++;
         $display("FAIL div_ff_7: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                  q, r, dz, e.q[7:0], e.r[7:0], e.dz);
      end
      checks++;
      if (done8 !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done=%b one cycle after done, expected 0", done8);
      end

      sb8.push_back('{64'h00, 64'h05, 1'b0});
      run8(8'd5, 8'd9, lat, bc, q, r, dz);
      e = sb8.pop_front();
      checks++;
      if (lat != 9 || q !== e.q[7:0] || r !== e.r[7:0] || dz !== e.dz) begin
         errors++;
         $display("FAIL div_5_9: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b lat=9",
                  q, r, dz, lat, e.q[7:0], e.r[7:0], e.dz);
      end

      for (int i = 0; i < 6; i++) begin
         sb8.push_back(model(64'(a_tab[i]), 64'(b_tab[i]), 8));
         run8(a_tab[i], b_tab[i], lat, bc, q, r, dz);
         e = sb8.pop_front();
         checks++;
         if (lat != 9 || q !== e.q[7:0] || r !== e.r[7:0] || dz !== e.dz) begin
            errors++;
            $display("FAIL pattern%0d %h/%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b lat=9",
                     i, a_tab[i], b_tab[i], q, r, dz, lat, e.q[7:0], e.r[7:0], e.dz);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, bc;
      logic [7:0] q, r;
      logic dz;
      exp_t e;
      sb8.push_back(model(64'h5A, 64'h0, 8));
      run8(8'h5A, 8'h00, lat, bc, q, r, dz);
      e = sb8.pop_front();
      checks++;
      if (lat != exp_lat(64'h0, 8)) begin
         errors++;
         $display("FAIL div0_latency: got %0d expected %0d", lat, exp_lat(64'h0, 8));
      end
      checks++;
      if (q !== 8'hFF || r !== 8'h5A || dz !== e.dz) begin
         errors++;
         $display("FAIL div0_result: got q=%h r=%h dz=%b expected q=ff r=5a dz=%b",
                  q, r, dz, e.dz);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pq, pr;
      logic pdz, stable, all_busy;
      int cyc;
      exp_t e;

      pq = q8; pr = r8; pdz = dz8;
      sb8.push_back(model(64'd100, 64'd7, 8));
      @(negedge clk);
      start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; dvd8 = 8'h33; dvs8 = 8'h01;
      cyc = 1; stable = 1'b1;
      while (!done8 && cyc < 200) begin
         if (q8 !== pq || r8 !== pr || dz8 !== pdz) stable = 1'b0;
         if (cyc == 4) begin
            start8 = 1'b1; dvd8 = 8'hAA; dvs8 = 8'h03;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      e = sb8.pop_front();
      checks++;
      if (cyc != 9) begin
         errors++;
         $display("FAIL b2b_first_latency: got %0d expected 9", cyc);
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold_during_run: outputs changed in RUN, expected held %h/%h", pq, pr);
      end
      checks++;
      if (q8 !== e.q[7:0] || r8 !== e.r[7:0] || q8 !== 8'd14 || r8 !== 8'd2) begin
         errors++;
         $display("FAIL b2b_first_result: got q=%0d r=%0d expected q=14 r=2", q8, r8);
      end

      pq = q8; pr = r8; pdz = dz8;
      start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd6;
      sb8.push_back('{64'd8, 64'd2, 1'b0});
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; dvd8 = 8'h11; dvs8 = 8'h00;
      cyc = 1; stable = 1'b1; all_busy = 1'b1;
      while (!done8 && cyc < 200) begin
         if (q8 !== pq || r8 !== pr || dz8 !== pdz) stable = 1'b0;
         if (busy8 !== 1'b1) all_busy = 1'b0;
         @(negedge clk);
         cyc++;
      end
      e = sb8.pop_front();
      checks++;
      if (cyc != 9 || all_busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_latency: got %0d busy_all=%b expected 9 busy_all=1", cyc, all_busy);
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold_between_dones: outputs changed, expected held %h/%h", pq, pr);
      end
      checks++;
      if (q8 !== e.q[7:0] || r8 !== e.r[7:0] || dz8 !== e.dz) begin
         errors++;
         $display("FAIL b2b_second_result: got q=%0d r=%0d dz=%b expected q=8 r=2 dz=0", q8, r8, dz8);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic saw;
      int lat, bc;
      logic [7:0] q, r;
      logic dz;
      exp_t e;

      sb8.push_back(model(64'd200, 64'd3, 8));
      @(negedge clk);
      start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_busy: got busy=%b expected 1", busy8);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
         errors++;
         $display("FAIL rst_async_clear: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                  busy8, done8, q8, r8, dz8);
      end
      sb8.delete();
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) saw = 1'b1;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_done: got activity after reset, expected idle");
      end
      sb8.push_back('{64'd3, 64'd0, 1'b0});
      run8(8'd9, 8'd3, lat, bc, q, r, dz);
      e = sb8.pop_front();
      checks++;
      if (lat != 9 || q !== e.q[7:0] || r !== e.r[7:0] || dz !== e.dz) begin
         errors++;
         $display("FAIL rst_restart_9_3: got q=%0d r=%0d lat=%0d expected q=3 r=0 lat=9", q, r, lat);
      end
   endtask

   task automatic test_latency64();
      int lat, bc;
      logic [63:0] q, r;
      logic dz;
      exp_t e;
      sb64.push_back('{64'd10, 64'd0, 1'b0});
      run64(64'd200, 64'd20, lat, bc, q, r, dz);
      e = sb64.pop_front();
      checks++;
      if (lat != 65 || bc != 64) begin
         errors++;
         $display("FAIL lat64: got lat=%0d busy=%0d expected lat=65 busy=64", lat, bc);
      end
      checks++;
      if (q !== e.q || r !== e.r || dz !== e.dz) begin
         errors++;
         $display("FAIL div64_200_20: got q=%0d r=%0d dz=%b expected q=10 r=0 dz=0", q, r, dz);
      end
   endtask

   task automatic test_random8();
      logic [7:0] a, b, q, r;
      logic dz;
      int lat, bc;
      exp_t e;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (i % 7 == 0) b = b >> $urandom_range(0, 7);
         if (i % 97 == 0) b = 8'd0;
         sb8.push_back(model(64'(a), 64'(b), 8));
         run8(a, b, lat, bc, q, r, dz);
         e = sb8.pop_front();
         checks++;
         if (lat != exp_lat(64'(b), 8) || q !== e.q[7:0] || r !== e.r[7:0] || dz !== e.dz) begin
            errors++;
            $display("FAIL rand8 %h/%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b",
                     a, b, q, r, dz, lat, e.q[7:0], e.r[7:0], e.dz);
         end
         if (b != 8'd0) begin
            checks++;
            if ((16'(q) * 16'(b) + 16'(r)) !== 16'(a) || r >= b) begin
               errors++;
               $display("FAIL rand8_identity %h/%h: got q=%h r=%h", a, b, q, r);
            end
         end
      end
   endtask

   task automatic test_random64();
      logic [63:0] a, b, q, r;
      logic dz;
      int lat, bc;
      exp_t e;
      for (int i = 0; i < 300; i++) begin
         a = {$urandom, $urandom} >> $urandom_range(0, 8);
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (i % 61 == 0) b = 64'd0;
         sb64.push_back(model(a, b, 64));
         run64(a, b, lat, bc, q, r, dz);
         e = sb64.pop_front();
         checks++;
         if (lat != exp_lat(b, 64) || q !== e.q || r !== e.r || dz !== e.dz) begin
            errors++;
            $display("FAIL rand64 %h/%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b",
                     a, b, q, r, dz, lat, e.q, e.r, e.dz);
         end
         if (b != 64'd0) begin
            checks++;
            if ((128'(q) * 128'(b) + 128'(r)) !== 128'(a) || r >= b) begin
               errors++;
               $display("FAIL rand64_identity %h/%h: got q=%h r=%h", a, b, q, r);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic8();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_latency64();
      test_random8();
      test_random64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
